missile_ctrl: RTL and testbench

MISSILE_CTRL -- requirements
Module: missile_ctrl

---
 rtl/missile_ctrl.sv | 135 +++++++++++++
 tb/tb_missile_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/missile_ctrl.sv
// Missile launch/flight/cooldown controller clocked by clk_25Hz.
// Optional MISSILE_AUTOFIRE_EN: holding fire re-launches after every cooldown.
module missile_ctrl #(
  parameter int SPEED    = 4,
  parameter int CD_TICKS = 16,
  parameter int X_MAX    = 584
) (
  input  logic       clk_25Hz,
  input  logic       rst,
  input  logic       move_tick,
  input  logic       fire,
  input  logic [9:0] r_x,
  input  logic [9:0] r_y,
  input  logic [3:0] Event,
  output logic [9:0] m_x,
  output logic [9:0] m_y,
  output logic       m_valid,
  output logic [7:0] hit_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } state_t;

  localparam int          CD_W    = (CD_TICKS < 1) ? 1 : $clog2(CD_TICKS + 1);
  localparam logic [10:0] X_MAX_W = 11'(X_MAX);
  localparam logic [10:0] SPEED_W = 11'(SPEED);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(CD_TICKS);
  localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);

  state_t          state_r;
  logic [CD_W-1:0] cd_cnt_r;
  logic            fire_d;
  logic            armed_r;

  logic [10:0] launch_x_s;
  logic [10:0] fly_x_s;
  logic        hit_s;
  logic        launch_req_s;

  assign launch_x_s = {1'b0, r_x} + 11'd40;
  assign fly_x_s    = {1'b0, m_x} + SPEED_W;
  assign hit_s      = |Event[3:1];

  // armed_r blocks a launch until fire has been seen low once since reset
`ifdef MISSILE_AUTOFIRE_EN
  assign launch_req_s = fire & armed_r;
`else
  assign launch_req_s = fire & ~fire_d & armed_r;
`endif

  // Missile FSM with registered position, valid flag, cooldown and hit counter
  always_ff @(posedge clk_25Hz or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      m_x      <= 10'd0;
      m_y      <= 10'd0;
      m_valid  <= 1'b0;
      hit_cnt  <= 8'd0;
      fire_d   <= 1'b0;
      armed_r  <= 1'b0;
      cd_cnt_r <= '0;
    end else begin
      fire_d  <= fire;
      armed_r <= armed_r | ~fire;
      case (state_r)
        IDLE: begin
          if (Event[0]) begin
            m_valid  <= 1'b0;
            cd_cnt_r <= '0;
          end else if (launch_req_s && (launch_x_s <= X_MAX_W)) begin
            state_r <= FLY;
            m_x     <= launch_x_s[9:0];
            m_y     <= r_y + 10'd9;
            m_valid <= 1'b1;
          end else begin
            m_valid <= 1'b0;
          end
        end
        FLY: begin
          if (hit_s) begin
            // A hit wins over motion; a simultaneous robot death still counts it
            hit_cnt <= (hit_cnt == 8'd255) ? 8'd255 : hit_cnt + 8'd1;
            m_valid <= 1'b0;
            if (Event[0]) begin
              state_r  <= IDLE;
              cd_cnt_r <= '0;
            end else begin
              state_r  <= COOL;
              cd_cnt_r <= CD_LOAD;
            end
          end else if (Event[0]) begin
            state_r  <= IDLE;
            m_valid  <= 1'b0;
            cd_cnt_r <= '0;
          end else if (move_tick) begin
            if (fly_x_s <= X_MAX_W) begin
              m_x <= fly_x_s[9:0];
            end else begin
              state_r  <= COOL;
              m_valid  <= 1'b0;
              cd_cnt_r <= CD_LOAD;
            end
          end else begin
            m_valid <= 1'b1;
          end
        end
        COOL: begin
          m_valid <= 1'b0;
          if (Event[0]) begin
            state_r  <= IDLE;
            cd_cnt_r <= '0;
          end else if (move_tick) begin
            if (cd_cnt_r <= CD_ONE) begin
              state_r  <= IDLE;
              cd_cnt_r <= '0;
            end else begin
              cd_cnt_r <= cd_cnt_r - CD_ONE;
            end
          end else begin
            cd_cnt_r <= cd_cnt_r;
          end
        end
        default: begin
          state_r  <= IDLE;
          m_valid  <= 1'b0;
          cd_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_missile_ctrl.sv
// Directed self-checking bench for missile_ctrl with default parameters.
module tb_missile_ctrl;

  logic       clk_25Hz = 1'b0;
  logic       rst      = 1'b0;
  logic       move_tick = 1'b0;
  logic       fire     = 1'b0;
  logic [9:0] r_x      = 10'd0;
  logic [9:0] r_y      = 10'd0;
  logic [3:0] Event    = 4'd0;
  logic [9:0] m_x;
  logic [9:0] m_y;
  logic       m_valid;
  logic [7:0] hit_cnt;

  int total = 0;
  int bad   = 0;

  missile_ctrl dut (
    .clk_25Hz (clk_25Hz),
    .rst      (rst),
    .move_tick(move_tick),
    .fire     (fire),
    .r_x      (r_x),
    .r_y      (r_y),
    .Event    (Event),
    .m_x      (m_x),
    .m_y      (m_y),
    .m_valid  (m_valid),
    .hit_cnt  (hit_cnt)
  );

  always #20 clk_25Hz = ~clk_25Hz;

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk_25Hz);
    #1;
  endtask

  task automatic mv();
    move_tick = 1'b1;
    step();
    move_tick = 1'b0;
  endtask

  task automatic fire_edge();
    fire = 1'b0;
    step();
    fire = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #5;
    total++;
    if ((m_valid !== 1'b0) || (m_x !== 10'd0) || (m_y !== 10'd0) || (hit_cnt !== 8'd0)) begin
      $display("FAIL reset_state: got v=%0b x=%0d y=%0d h=%0d want 0 0 0 0", m_valid, m_x, m_y, hit_cnt);
      bad++;
    end
    fire = 1'b1;
    r_x  = 10'd100;
    r_y  = 10'd200;
    step();
    rst = 1'b1;
    step();
    step();
    step();
    total++;
    if (m_valid !== 1'b0) begin
      $display("FAIL reset_fire_held: got v=%0b want 0", m_valid);
      bad++;
    end
  endtask

  task automatic test_launch();
    fire_edge();
    total++;
    if ((m_valid !== 1'b1) || (m_x !== 10'd140) || (m_y !== 10'd209)) begin
      $display("FAIL launch: got v=%0b x=%0d y=%0d want 1 140 209", m_valid, m_x, m_y);
      bad++;
    end
    mv();
    mv();
    mv();
    total++;
    if ((m_x !== 10'd152) || (m_valid !== 1'b1)) begin
      $display("FAIL fly3: got v=%0b x=%0d want 1 152", m_valid, m_x);
      bad++;
    end
  endtask

  task automatic test_hit_cooldown();
    Event = 4'b0100;
    mv();
    Event = 4'b0000;
    total++;
    if ((m_x !== 10'd152) || (m_valid !== 1'b0) || (hit_cnt !== 8'd1)) begin
      $display("FAIL hit: got v=%0b x=%0d h=%0d want 0 152 1", m_valid, m_x, hit_cnt);
      bad++;
    end
    fire = 1'b0;
    step();
    for (int i = 0; i < 15; i++) mv();
    fire = 1'b1;
    step();
    fire = 1'b0;
    step();
    total++;
    if (m_valid !== 1'b0) begin
      $display("FAIL cool_fire_drop: got v=%0b want 0", m_valid);
      bad++;
    end
    mv();
    fire = 1'b1;
    step();
    total++;
    if ((m_valid !== 1'b1) || (m_x !== 10'd140)) begin
      $display("FAIL relaunch: got v=%0b x=%0d want 1 140", m_valid, m_x);
      bad++;
    end
    Event = 4'b0001;
    step();
    Event = 4'b0000;
    total++;
    if ((m_valid !== 1'b0) || (m_x !== 10'd140) || (m_y !== 10'd209)) begin
      $display("FAIL abort_hold: got v=%0b x=%0d y=%0d want 0 140 209", m_valid, m_x, m_y);
      bad++;
    end
  endtask

  task automatic test_boundary();
    r_x = 10'd540;
    fire_edge();
    total++;
    if ((m_valid !== 1'b1) || (m_x !== 10'd580)) begin
      $display("FAIL edge_launch: got v=%0b x=%0d want 1 580", m_valid, m_x);
      bad++;
    end
    mv();
    total++;
    if ((m_valid !== 1'b1) || (m_x !== 10'd584)) begin
      $display("FAIL edge_584: got v=%0b x=%0d want 1 584", m_valid, m_x);
      bad++;
    end
    mv();
    total++;
    if ((m_valid !== 1'b0) || (m_x !== 10'd584) || (hit_cnt !== 8'd1)) begin
      $display("FAIL edge_out: got v=%0b x=%0d h=%0d want 0 584 1", m_valid, m_x, hit_cnt);
      bad++;
    end
    Event = 4'b0001;
    step();
    Event = 4'b0000;
  endtask

  task automatic test_no_launch();
    r_x = 10'd550;
    fire_edge();
    step();
    total++;
    if (m_valid !== 1'b0) begin
      $display("FAIL drop_far: got v=%0b want 0", m_valid);
      bad++;
    end
    r_x = 10'd100;
    fire_edge();
    Event = 4'b0001;
    step();
    Event = 4'b0000;
    total++;
    if ((m_valid !== 1'b0) || (hit_cnt !== 8'd1)) begin
      $display("FAIL fly_abort: got v=%0b h=%0d want 0 1", m_valid, hit_cnt);
      bad++;
    end
    fire_edge();
    Event = 4'b1001;
    step();
    Event = 4'b0000;
    total++;
    if ((m_valid !== 1'b0) || (hit_cnt !== 8'd2)) begin
      $display("FAIL hit_and_die: got v=%0b h=%0d want 0 2", m_valid, hit_cnt);
      bad++;
    end
    fire_edge();
    total++;
    if (m_valid !== 1'b1) begin
      $display("FAIL idle_after_hit_die: got v=%0b want 1", m_valid);
      bad++;
    end
    Event = 4'b0001;
    step();
    Event = 4'b1110;
    step();
    step();
    Event = 4'b0000;
    total++;
    if ((hit_cnt !== 8'd2) || (m_valid !== 1'b0)) begin
      $display("FAIL idle_ignore_hit: got v=%0b h=%0d want 0 2", m_valid, hit_cnt);
      bad++;
    end
  endtask

  task automatic test_saturate_and_reset();
    for (int i = 0; i < 256; i++) begin
      fire_edge();
      Event = 4'b1011;
      step();
      Event = 4'b0000;
    end
    total++;
    if (hit_cnt !== 8'd255) begin
      $display("FAIL saturate: got h=%0d want 255", hit_cnt);
      bad++;
    end
    fire_edge();
    total++;
    if (m_valid !== 1'b1) begin
      $display("FAIL pre_reset_launch: got v=%0b want 1", m_valid);
      bad++;
    end
    #5;
    rst = 1'b0;
    #2;
    total++;
    if ((m_valid !== 1'b0) || (m_x !== 10'd0) || (m_y !== 10'd0) || (hit_cnt !== 8'd0)) begin
      $display("FAIL async_reset: got v=%0b x=%0d y=%0d h=%0d want 0 0 0 0", m_valid, m_x, m_y, hit_cnt);
      bad++;
    end
    step();
    rst = 1'b1;
  endtask

  task automatic test_autofire();
    r_x  = 10'd540;
    fire = 1'b0;
    step();
    fire = 1'b1;
    step();
    total++;
    if ((m_valid !== 1'b1) || (m_x !== 10'd580)) begin
      $display("FAIL auto_first: got v=%0b x=%0d want 1 580", m_valid, m_x);
      bad++;
    end
    mv();
    mv();
    for (int i = 0; i < 16; i++) mv();
    total++;
    if (m_valid !== 1'b0) begin
      $display("FAIL auto_cool_exit: got v=%0b want 0", m_valid);
      bad++;
    end
    step();
`ifdef MISSILE_AUTOFIRE_EN
    total++;
    if ((m_valid !== 1'b1) || (m_x !== 10'd580)) begin
      $display("FAIL auto_relaunch: got v=%0b x=%0d want 1 580", m_valid, m_x);
      bad++;
    end
`else
    step();
    step();
    total++;
    if (m_valid !== 1'b0) begin
      $display("FAIL single_launch: got v=%0b want 0", m_valid);
      bad++;
    end
`endif
    fire = 1'b0;
  endtask

  initial begin
    test_reset();
    test_launch();
    test_hit_cooldown();
    test_boundary();
    test_no_launch();
    test_saturate_and_reset();
    test_autofire();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
